// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param
// Parametrised raster timing generator. Each line and each frame runs through
// four regions in order: sync, back porch, active, front porch. The widths of
// the regions, the sync polarities and the output delay depth are parameters.
// The outputs can be delayed so that they stay aligned with a pixel pipeline
// of known depth further downstream.
//
// Ports:
//   pclk        - pixel clock
//   reset       - asynchronous reset, active high
//   ce          - pixel clock-enable; no state changes while ce=0
//   en          - run enable; while en=0 the raster is stopped and blanked
//   hsync       - horizontal sync, active level HS_POL
//   vsync       - vertical sync, active level VS_POL
//   data_valid  - high during active video
//   px_x        - zero-based column inside the active region, 0 outside it
//   px_y        - zero-based row inside the active lines, 0 outside them
//   line_start  - one ce-cycle pulse at the first pixel of every line
//   frame_start - one ce-cycle pulse at the first pixel of every frame
//
// The outputs show the counter state from 1+DLY ce-cycles earlier.
module vga_timing_gen_param #(
    parameter int CNT_W    = 12,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DLY      = 0
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             ce,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             data_valid,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_AST   = H_SYNC + H_BACK;
    localparam int V_AST   = V_SYNC + V_BACK;

    if ((longint'(H_TOTAL) > (longint'(1) << CNT_W)) ||
        (longint'(V_TOTAL) > (longint'(1) << CNT_W))) begin : gBadWidth
        $error("vga_timing_gen_param: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if ((H_SYNC < 1) || (H_ACTIVE < 1) || (V_SYNC < 1) || (V_ACTIVE < 1) ||
        (H_BACK < 0) || (H_FRONT < 0) || (V_BACK < 0) || (V_FRONT < 0)) begin : gBadRegion
        $error("vga_timing_gen_param: sync and active regions must be at least 1 wide");
    end
    if ((DLY < 0) || (DLY > 15)) begin : gBadDly
        $error("vga_timing_gen_param: DLY must be 0..15");
    end

    // All comparisons are made in CNT_W bits. The active region is bounded by
    // its last index rather than one past it, because one past it can wrap to
    // zero when the front porch is empty and the total is exactly 2^CNT_W.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_AFIRST = CNT_W'(H_AST);
    localparam logic [CNT_W-1:0] V_AFIRST = CNT_W'(V_AST);
    localparam logic [CNT_W-1:0] H_ALAST  = CNT_W'(H_AST + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ALAST  = CNT_W'(V_AST + V_ACTIVE - 1);

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             dv;
        logic             ls;
        logic             fs;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } stage_t;

    localparam stage_t IDLE = '{hs: ~HS_POL, vs: ~VS_POL, dv: 1'b0, ls: 1'b0,
                                fs: 1'b0, x: '0, y: '0};

    logic [CNT_W-1:0] hCnt;
    logic [CNT_W-1:0] vCnt;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (ce) begin
            if (!en) begin
                hCnt <= '0;
                vCnt <= '0;
            end else if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
        end
    end

    logic   hsAct;
    logic   vsAct;
    logic   hAct;
    logic   vAct;
    stage_t nxt;

    always_comb begin
        hsAct = (hCnt < HS_END);
        vsAct = (vCnt < VS_END);
        hAct  = (hCnt >= H_AFIRST) && (hCnt <= H_ALAST);
        vAct  = (vCnt >= V_AFIRST) && (vCnt <= V_ALAST);

        nxt = IDLE;
        if (en) begin
            nxt.hs = hsAct ? HS_POL : ~HS_POL;
            nxt.vs = vsAct ? VS_POL : ~VS_POL;
            nxt.dv = hAct & vAct;
            nxt.ls = (hCnt == '0);
            nxt.fs = (hCnt == '0) && (vCnt == '0);
            nxt.x  = hAct ? hCnt - H_AFIRST : '0;
            nxt.y  = vAct ? vCnt - V_AFIRST : '0;
        end
    end

    // pipe[0] is the registered decode; pipe[1..DLY] is the alignment delay.
    stage_t pipe [0:DLY];

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DLY; i++) begin
                pipe[i] <= IDLE;
            end
        end else if (ce) begin
            pipe[0] <= nxt;
            for (int i = 1; i <= DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hsync       = pipe[DLY].hs;
    assign vsync       = pipe[DLY].vs;
    assign data_valid  = pipe[DLY].dv;
    assign line_start  = pipe[DLY].ls;
    assign frame_start = pipe[DLY].fs;
    assign px_x        = pipe[DLY].x;
    assign px_y        = pipe[DLY].y;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
module tb_vga_timing_gen_param;

    localparam int CW = 12;
    localparam int HT = 16;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic pclk = 1'b0;
    logic reset;
    logic ce;
    logic en;

    always #5 pclk = ~pclk;

    logic          hsA, vsA, dvA, lsA, fsA;
    logic [CW-1:0] xA, yA;
    logic          hsB, vsB, dvB, lsB, fsB;
    logic [CW-1:0] xB, yB;
    logic          hsC, vsC, dvC, lsC, fsC;
    logic [CW-1:0] xC, yC;

    vga_timing_gen_param #(
        .CNT_W(CW), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DLY(0)
    ) dutA (
        .pclk(pclk), .reset(reset), .ce(ce), .en(en),
        .hsync(hsA), .vsync(vsA), .data_valid(dvA), .px_x(xA), .px_y(yA),
        .line_start(lsA), .frame_start(fsA)
    );

    vga_timing_gen_param #(
        .CNT_W(CW), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DLY(0)
    ) dutB (
        .pclk(pclk), .reset(reset), .ce(ce), .en(en),
        .hsync(hsB), .vsync(vsB), .data_valid(dvB), .px_x(xB), .px_y(yB),
        .line_start(lsB), .frame_start(fsB)
    );

    vga_timing_gen_param #(
        .CNT_W(CW), .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DLY(3)
    ) dutC (
        .pclk(pclk), .reset(reset), .ce(ce), .en(en),
        .hsync(hsC), .vsync(vsC), .data_valid(dvC), .px_x(xC), .px_y(yC),
        .line_start(lsC), .frame_start(fsC)
    );

    // Reference: position within the frame as a single ce-cycle index, decoded
    // with plain arithmetic; pipe[k] is what a k-stage-delayed output shows.
    typedef struct {
        bit hs;
        bit vs;
        bit dv;
        bit ls;
        bit fs;
        int x;
        int y;
    } exp_t;

    exp_t pipe [0:3];
    int   pos;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t inact();
        exp_t e;
        e.hs = 0; e.vs = 0; e.dv = 0; e.ls = 0; e.fs = 0; e.x = 0; e.y = 0;
        return e;
    endfunction

    function automatic exp_t dec(input int p);
        exp_t e;
        int   h;
        int   v;
        bit   ha;
        bit   va;
        h    = p % HT;
        v    = p / HT;
        ha   = (h >= 6) && (h < 14);
        va   = (v >= 2) && (v < 6);
        e.hs = (h < 4);
        e.vs = (v < 1);
        e.dv = ha && va;
        e.x  = ha ? h - 6 : 0;
        e.y  = va ? v - 2 : 0;
        e.ls = (h == 0);
        e.fs = (p == 0);
        return e;
    endfunction

    task automatic modelReset();
        pos = 0;
        for (int i = 0; i < 4; i++) pipe[i] = inact();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkStage(input string p, input logic hs, input logic vs, input logic dv,
                            input logic ls, input logic fs, input logic [CW-1:0] x,
                            input logic [CW-1:0] y, input exp_t e, input bit pol);
        chk({p, ".hsync"}, 32'(hs), 32'(e.hs ? pol : !pol));
        chk({p, ".vsync"}, 32'(vs), 32'(e.vs ? pol : !pol));
        chk({p, ".data_valid"}, 32'(dv), 32'(e.dv));
        chk({p, ".line_start"}, 32'(ls), 32'(e.ls));
        chk({p, ".frame_start"}, 32'(fs), 32'(e.fs));
        chk({p, ".px_x"}, 32'(x), e.x);
        chk({p, ".px_y"}, 32'(y), e.y);
    endtask

    task automatic checkAll();
        chkStage("A", hsA, vsA, dvA, lsA, fsA, xA, yA, pipe[0], 1'b0);
        chkStage("B", hsB, vsB, dvB, lsB, fsB, xB, yB, pipe[0], 1'b1);
        chkStage("C", hsC, vsC, dvC, lsC, fsC, xC, yC, pipe[3], 1'b0);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        if (!reset && ce) begin
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = en ? dec(pos) : inact();
            pos     = en ? (pos + 1) % FT : 0;
        end
        checkAll();
    endtask

    // Runs n ce=1,en=1 cycles right after reset release with directed checks
    // on the first-frame timing of the small mode.
    task automatic runFromRelease(input int n);
        int hsHi = 0;
        int vsHi = 0;
        int fsCnt = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k <= 4) chk("rel.hsync_low", 32'(hsA), 0);
            if (k == 5) chk("rel.hsync_high", 32'(hsA), 1);
            if (k == 38) chk("rel.dv_before", 32'(dvA), 0);
            if (k == 39) begin
                chk("rel.dv_first", 32'(dvA), 1);
                chk("rel.px_x_first", 32'(xA), 0);
                chk("rel.px_y_first", 32'(yA), 0);
            end
            if (k >= 39 && k <= 46) chk("rel.px_x_ramp", 32'(xA), k - 39);
            if (k <= FT) begin
                hsHi  += int'(hsB);
                vsHi  += int'(vsB);
                fsCnt += int'(fsA);
            end
            if (k == FT + 1) chk("rel.fs_period", 32'(fsA), 1);
        end
        if (n >= FT) begin
            chk("pol.hsync_high_count", hsHi, 28);
            chk("pol.vsync_high_count", vsHi, 16);
            chk("rel.fs_per_frame", fsCnt, 1);
        end
    endtask

    initial begin
        int n;
        int fsCnt;

        reset = 1'b1;
        ce    = 1'b1;
        en    = 1'b1;
        modelReset();
        repeat (3) tick();
        chk("rst.hsyncA", 32'(hsA), 1);
        chk("rst.hsyncB", 32'(hsB), 0);
        chk("rst.vsyncB", 32'(vsB), 0);

        reset = 1'b0;
        runFromRelease(130);

        fsCnt = 0;
        for (int k = 0; k < 240; k++) begin
            ce = (k % 2 == 0);
            tick();
            if (k >= 8 && k < 232) fsCnt += int'(fsA);
        end
        chk("ce.fs_pclk_per_224", fsCnt, 2);
        ce = 1'b1;

        n = 0;
        while (pos != 3 * HT + 10 && n < 300) begin
            tick();
            n++;
        end
        chk("en.reach_h10_v3", pos, 3 * HT + 10);
        chk("en.active_before_drop", 32'(dvA), 1);
        en = 1'b0;
        tick();
        chk("en.dv_off", 32'(dvA), 0);
        chk("en.hsync_inactive", 32'(hsA), 1);
        chk("en.vsync_inactive", 32'(vsA), 1);
        chk("en.px_x_zero", 32'(xA), 0);
        chk("en.px_y_zero", 32'(yA), 0);
        repeat (3) tick();
        en = 1'b1;
        tick();
        chk("en.fs_restart", 32'(fsA), 1);
        chk("en.ls_restart", 32'(lsA), 1);
        repeat (37) tick();
        chk("en.dv_before", 32'(dvA), 0);
        tick();
        chk("en.dv_first", 32'(dvA), 1);
        chk("en.px_y_first", 32'(yA), 0);

        for (int k = 0; k < 800; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 39) != 0);
            tick();
        end

        ce = 1'b1;
        en = 1'b1;
        n  = 0;
        while (pos != 9 && n < 300) begin
            tick();
            n++;
        end
        chk("rst.reach_h9", pos, 9);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("rst.async_hsyncA", 32'(hsA), 1);
        repeat (2) tick();
        reset = 1'b0;
        runFromRelease(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
